keypad_decoder: RTL and testbench

- Consumes the one-cycle octave/mode press pulses produced by the keypad front end, plus the raw 13-key note keypad.
- Produces the registered synth control state: current octave, waveform mode, debounced note index/valid, and a note-change strobe.
- Sits between the keypad front end and the oscillator/divider block.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_decoder_sync.sv | 28 ++
 rtl/keypad_decoder.sv | 147 ++++++++++++++
 tb/tb_keypad_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad decoder slice.
//   mode_t           : waveform selection, 2-bit encoding SQUARE..SINE
//   NUM_KEYS_DEFAULT : number of note keys on the standard keypad (C..C')
//   NOTE_IDX_W       : width of a note index
package keypad_pkg;

  typedef enum logic [1:0] {
    SQUARE   = 2'd0,
    SAW      = 2'd1,
    TRIANGLE = 2'd2,
    SINE     = 2'd3
  } mode_t;

  localparam int unsigned NUM_KEYS_DEFAULT = 13;
  localparam int unsigned NOTE_IDX_W       = 4;

endpackage

// File: rtl/keypad_decoder_sync.sv
// Two-flop synchronizer for one asynchronous level input.
//   clk   : destination clock
//   n_rst : asynchronous active-low reset, clears both stages
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges behind d
module keypad_decoder_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_decoder.sv
// Synth control decoder: octave counter, waveform mode FSM and debounced note key.
//   clk          : system clock
//   n_rst        : asynchronous active-low reset
//   octave_pulse : one-cycle synchronized octave-step pulse (held high = one step per cycle)
//   mode_pulse   : one-cycle synchronized mode-step pulse
//   keys         : raw asynchronous active-high key levels, bit 0 = lowest note
//   octave       : current octave, 0..MAX_OCTAVE, wraps to 0
//   mode         : current waveform (mode_t encoding)
//   note_idx     : index of accepted key
//   note_valid   : a key is accepted as held
//   note_change  : one-cycle strobe whenever {note_valid, note_idx} updates
// DEBOUNCE must be at least 1.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned MAX_OCTAVE = 4,
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEFAULT,
  parameter int unsigned DEBOUNCE   = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  octave_pulse,
  input  logic                  mode_pulse,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [2:0]            octave,
  output logic [1:0]            mode,
  output logic [NOTE_IDX_W-1:0] note_idx,
  output logic                  note_valid,
  output logic                  note_change
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE + 1);
  localparam logic [2:0]     OctMax = 3'(MAX_OCTAVE);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE);

  // ---------------------------------------------------------------------------
  // Octave counter and mode FSM (independent of the key path)
  // ---------------------------------------------------------------------------
  logic [2:0] octave_q;
  mode_t      mode_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      octave_q <= 3'd0;
    end else if (octave_pulse) begin
      octave_q <= (octave_q == OctMax) ? 3'd0 : octave_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q <= SQUARE;
    end else if (mode_pulse) begin
      unique case (mode_q)
        SQUARE:   mode_q <= SAW;
        SAW:      mode_q <= TRIANGLE;
        TRIANGLE: mode_q <= SINE;
        SINE:     mode_q <= SQUARE;
      endcase
    end
  end

  assign octave = octave_q;
  assign mode   = mode_q;

  // ---------------------------------------------------------------------------
  // Key synchronizers
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] keys_sync;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    keypad_decoder_sync u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (keys[i]),
      .q     (keys_sync[i])
    );
  end

  // Priority encoder: scan high to low so the lowest set bit is written last and wins.
  logic                  cand_valid;
  logic [NOTE_IDX_W-1:0] cand_idx;

  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (keys_sync[i]) begin
        cand_valid = 1'b1;
        cand_idx   = NOTE_IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic                  pend_valid_q, pend_valid_d;
  logic [NOTE_IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  note_valid_q;
  logic [NOTE_IDX_W-1:0] note_idx_q;
  logic                  note_change_q;
  logic                  accept;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    cnt_d        = cnt_q;
    if ({cand_valid, cand_idx} != {pend_valid_q, pend_idx_q}) begin
      // A new candidate counts as its own first stable cycle.
      pend_valid_d = cand_valid;
      pend_idx_d   = cand_idx;
      cnt_d        = CntW'(1);
    end else if (cnt_q != DebMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Decided on next-state so the output updates on the edge the DEBOUNCE-th stable
    // cycle completes; the saturated counter plus equal outputs stops any repeat.
    accept = (cnt_d == DebMax) && ({pend_valid_d, pend_idx_d} != {note_valid_q, note_idx_q});
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_valid_q  <= 1'b0;
      pend_idx_q    <= '0;
      cnt_q         <= '0;
      note_valid_q  <= 1'b0;
      note_idx_q    <= '0;
      note_change_q <= 1'b0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_idx_q    <= pend_idx_d;
      cnt_q         <= cnt_d;
      note_change_q <= accept;
      if (accept) begin
        note_valid_q <= pend_valid_d;
        note_idx_q   <= pend_idx_d;
      end
    end
  end

  assign note_valid  = note_valid_q;
  assign note_idx    = note_idx_q;
  assign note_change = note_change_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: table-driven octave/mode vectors through a one-cycle scoreboard,
// plus hand-written key sequences whose expected note_change events sit in a queue.
module tb_keypad_decoder;

  localparam int unsigned MaxOct = 4;
  localparam int unsigned NKeys  = 13;
  localparam int unsigned Deb    = 16;
  localparam int          Lat    = 2 + Deb;  // negedges from key change to strobe

  logic             clk;
  logic             n_rst;
  logic             octave_pulse;
  logic             mode_pulse;
  logic [NKeys-1:0] keys;
  logic [2:0]       octave;
  logic [1:0]       mode;
  logic [3:0]       note_idx;
  logic             note_valid;
  logic             note_change;

  keypad_decoder #(
    .MAX_OCTAVE (MaxOct),
    .NUM_KEYS   (NKeys),
    .DEBOUNCE   (Deb)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .octave_pulse (octave_pulse),
    .mode_pulse   (mode_pulse),
    .keys         (keys),
    .octave       (octave),
    .mode         (mode),
    .note_idx     (note_idx),
    .note_valid   (note_valid),
    .note_change  (note_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic op;
    logic mp;
    int   oct;
    int   md;
  } vec_t;

  typedef struct {
    int oct;
    int md;
  } om_t;

  typedef struct {
    int valid;
    int idx;
    int at;
  } ev_t;

  vec_t vecs[21];
  om_t  sb_q[$];
  ev_t  ev_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: land on the next negedge and score any note_change strobe.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (note_change) begin
      if (ev_q.size() == 0) begin
        check("spurious_strobe", 1, 0);
      end else begin
        e = ev_q.pop_front();
        check("strobe_cycle", cyc, e.at);
        check("strobe_valid", int'(note_valid), e.valid);
        check("strobe_idx", int'(note_idx), e.idx);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_note(input int valid, input int idx);
    ev_t e;
    e.valid = valid;
    e.idx   = idx;
    e.at    = cyc + Lat;
    ev_q.push_back(e);
  endtask

  initial begin
    om_t got_exp;
    int  lows;

    vecs[0]  = '{1'b1, 1'b0, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 1'b0, 3, 0};
    vecs[3]  = '{1'b1, 1'b0, 4, 0};
    vecs[4]  = '{1'b1, 1'b0, 0, 0};  // wrap at MAX_OCTAVE
    vecs[5]  = '{1'b0, 1'b0, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1, 0};  // 3-cycle-wide pulse
    vecs[7]  = '{1'b1, 1'b0, 2, 0};
    vecs[8]  = '{1'b1, 1'b0, 3, 0};
    vecs[9]  = '{1'b0, 1'b0, 3, 0};
    vecs[10] = '{1'b0, 1'b1, 3, 1};
    vecs[11] = '{1'b0, 1'b1, 3, 2};
    vecs[12] = '{1'b0, 1'b1, 3, 3};
    vecs[13] = '{1'b0, 1'b1, 3, 0};
    vecs[14] = '{1'b1, 1'b1, 4, 1};  // simultaneous
    vecs[15] = '{1'b1, 1'b1, 0, 2};
    vecs[16] = '{1'b0, 1'b0, 0, 2};
    vecs[17] = '{1'b1, 1'b0, 1, 2};
    vecs[18] = '{1'b1, 1'b0, 2, 2};
    vecs[19] = '{1'b1, 1'b0, 3, 2};
    vecs[20] = '{1'b0, 1'b0, 3, 2};

    n_rst        = 1'b0;
    octave_pulse = 1'b0;
    mode_pulse   = 1'b0;
    keys         = '0;
    ticks(3);
    check("rst_octave", int'(octave), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_note_idx", int'(note_idx), 0);
    check("rst_note_valid", int'(note_valid), 0);
    check("rst_note_change", int'(note_change), 0);
    n_rst = 1'b1;

    // Octave/mode table: each vector's result is checked one cycle after it is driven.
    for (int i = 0; i < 21; i++) begin
      tick();
      if (sb_q.size() > 0) begin
        got_exp = sb_q.pop_front();
        check($sformatf("vec%0d_octave", i - 1), int'(octave), got_exp.oct);
        check($sformatf("vec%0d_mode", i - 1), int'(mode), got_exp.md);
      end
      octave_pulse = vecs[i].op;
      mode_pulse   = vecs[i].mp;
      sb_q.push_back('{vecs[i].oct, vecs[i].md});
    end
    tick();
    octave_pulse = 1'b0;
    mode_pulse   = 1'b0;
    got_exp = sb_q.pop_front();
    check("vec20_octave", int'(octave), got_exp.oct);
    check("vec20_mode", int'(mode), got_exp.md);
    ticks(2);

    // Clean press of key 4.
    keys = 13'h0010;
    expect_note(1, 4);
    ticks(Lat - 1);
    check("press_not_yet", int'(note_valid), 0);
    tick();
    check("press_valid", int'(note_valid), 1);
    check("press_idx", int'(note_idx), 4);
    ticks(1);
    check("press_strobe_low", int'(note_change), 0);
    ticks(40 - Lat - 1);
    check("press_events_left", ev_q.size(), 0);

    // Release.
    keys = '0;
    expect_note(0, 0);
    ticks(40);
    check("release_events_left", ev_q.size(), 0);
    check("release_valid", int'(note_valid), 0);

    // Bounce on key 7: 12 runs of 5 cycles, then stable on.
    for (int s = 0; s < 12; s++) begin
      keys = (s % 2 == 0) ? 13'h0080 : 13'h0000;
      ticks(5);
    end
    keys = 13'h0080;
    expect_note(1, 7);
    ticks(30);
    check("bounce_events_left", ev_q.size(), 0);
    check("bounce_idx", int'(note_idx), 7);
    check("bounce_valid", int'(note_valid), 1);

    // Priority: keys 9 and 2 together, then release 2.
    keys = 13'h0204;
    expect_note(1, 2);
    ticks(30);
    check("prio_events_left", ev_q.size(), 0);
    check("prio_idx", int'(note_idx), 2);
    keys = 13'h0200;
    expect_note(1, 9);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!note_valid) lows++;
    end
    check("prio_release_events_left", ev_q.size(), 0);
    check("prio_release_idx", int'(note_idx), 9);
    check("prio_valid_dropouts", lows, 0);

    // Asynchronous reset mid-run with octave=3, mode=TRIANGLE, note 9 held.
    check("pre_rst_octave", int'(octave), 3);
    check("pre_rst_mode", int'(mode), 2);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_octave", int'(octave), 0);
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_note_idx", int'(note_idx), 0);
    check("async_rst_note_valid", int'(note_valid), 0);
    ticks(2);
    check("held_rst_octave", int'(octave), 0);
    check("held_rst_valid", int'(note_valid), 0);
    check("held_rst_change", int'(note_change), 0);
    n_rst = 1'b1;
    // Key still held: it must go through the full sync + debounce path again.
    expect_note(1, 9);
    ticks(30);
    check("post_rst_events_left", ev_q.size(), 0);
    check("post_rst_idx", int'(note_idx), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
